uart_cmd_framer: RTL and testbench
==================================

Name: uart_cmd_framer

Overview:
Sits between the UART byte receiver and the command decoder. Assembles a framed 4-byte UART packet into the 20-bit command word and checks it for errors. Presents each valid word for exactly one cycle, then returns the command bus to an idle code that matches no command. Counts malformed or timed-out frames for debug display.

Parameters:
TIMEOUT_CYCLES, 50000, max clk cycles allowed between consecutive bytes of one frame (1 ms at 50 MHz)
HEADER, 8'hA5, frame start byte
IDLE_WORD, 20'h00000, value driven on cmd_data when no command is presented

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
rx_data  input  8  received byte from UART RX
rx_valid  input  1  one-cycle strobe, rx_data valid
cmd_data  output  20  command word to decoder; IDLE_WORD except during cmd_valid cycle
cmd_valid  output  1  one-cycle strobe coincident with valid cmd_data
frame_err  output  1  one-cycle strobe on any rejected frame
err_cnt  output  8  saturating count of rejected frames

Behaviour:
- Reset (async, rst=1): state=IDLE, cmd_data=IDLE_WORD, cmd_valid=0, frame_err=0, err_cnt=0, timeout counter=0, shift regs=0.
- Frame on the wire: HEADER, B1={4'h0,cmd[19:16]}, B2=cmd[15:8], B3=cmd[7:0], CK = B1^B2^B3.
- States: IDLE -> GOT_HDR -> GOT_B1 -> GOT_B2 -> GOT_B3 -> IDLE.
- IDLE: rx_valid with rx_data==HEADER -> GOT_HDR; any other byte is discarded silently (no error, no count).
- GOT_HDR: rx_valid -> latch B1, go GOT_B1. B1[7:4]!=0 is not rejected here; it is checked at CK.
- GOT_B1 / GOT_B2: rx_valid -> latch B2 / B3 and advance.
- GOT_B3: rx_valid -> compare rx_data with B1^B2^B3. Pass requires match AND B1[7:4]==0. Go to IDLE either way.
- A HEADER value received mid-frame is treated as ordinary data. There is no resync; the checksum rejects misaligned frames.
- Accept latency: on the cycle after the CK byte's rx_valid, cmd_valid=1 and cmd_data={B1[3:0],B2,B3}. On the following cycle, cmd_valid=0 and cmd_data=IDLE_WORD.
- Reject: on the cycle after CK, frame_err=1 for one cycle; err_cnt increments and saturates at 8'hFF. cmd_valid stays 0 and cmd_data stays IDLE_WORD.
- Timeout: the counter runs in every non-IDLE state, clears on each accepted byte, and holds at 0 in IDLE.
  - If the counter reaches TIMEOUT_CYCLES-1 with no rx_valid that cycle -> return to IDLE, pulse frame_err, increment err_cnt (saturating).
  - If rx_valid arrives on that same cycle, the byte wins: it is accepted, and there is no timeout.
- Back-to-back frames: the HEADER of the next frame may arrive on the cycle immediately after CK and must be accepted. IDLE is entered on the same edge that registers the outcome, so the outputs and the new state do not conflict.
- Reset mid-frame aborts with no error count. Outputs are forced to reset values immediately.
- Widths: timeout counter sized by $clog2(TIMEOUT_CYCLES). Checksum is 8-bit XOR with no carry.

Decomposition:
- Shared package (uart_pkg): HEADER default, IDLE_WORD, state enum encoding, and command code constants (20'hFFFxx group, 8'hFD freq prefix). The decoder and host-side scripts then use the same values.
- One natural sub-module: uart_byte_timeout (counter with clear/enable, expiry flag with rx_valid-priority). Everything else stays in the framer.

Test Plan:
1. Bytes A5,0F,FF,E4,14 (CK=0F^FF^E4=14) -> cmd_valid high for 1 cycle with cmd_data=20'hFFFE4, then cmd_data=20'h00000; err_cnt=0.
2. Bytes A5,0F,D1,F4,2A (CK=0F^D1^F4=2A) -> cmd_data=20'hFD1F4 (freq 500) for one cycle. Then a wrong CK (A5,0F,D1,F4,00) -> frame_err pulse, err_cnt=1, no cmd_valid.
3. A5,0F then silence for TIMEOUT_CYCLES (parameter set to 100) -> frame_err at cycle 100 after last byte, state IDLE. Next good frame is accepted normally. Also cover a byte landing exactly on cycle 99 -> accepted, no error.
4. Bytes A5,1F,FF,F0,CK where CK=1F^FF^F0 -> rejected for nonzero B1 nibble: err_cnt+1, no cmd_valid. Garbage 00,33 before a header -> ignored, err_cnt unchanged.
5. Two valid frames with rx_valid on consecutive cycles (10 strobes back-to-back) -> two cmd_valid pulses, each one cycle, correct words. Then 260 bad frames -> err_cnt saturates at 8'hFF.
6. Assert rst between B2 and B3 -> all outputs at reset values asynchronously, err_cnt=0. The remaining bytes (B3, CK) are discarded in IDLE with no error.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Values shared by the UART command framer, the command decoder and the
// host-side tooling: the frame header, the idle command word, the framer
// state encoding, the command code groups, and the byte-level helpers.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam logic [7:0]  HEADER_DEFAULT    = 8'hA5;
   localparam logic [19:0] IDLE_WORD_DEFAULT = 20'h00000;

   // Command code groups seen by the decoder: 20'hFFFxx are discrete
   // commands, 8'hFD in cmd[19:12] prefixes a frequency setting.
   localparam logic [11:0] CMD_GROUP_PREFIX = 12'hFFF;
   localparam logic [7:0]  CMD_FREQ_PREFIX  = 8'hFD;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_GOT_HDR = 3'd1,
      ST_GOT_B1  = 3'd2,
      ST_GOT_B2  = 3'd3,
      ST_GOT_B3  = 3'd4
   } frame_state_t;

   // Frame check byte: plain 8-bit XOR of the three payload bytes.
   function automatic logic [7:0] frame_checksum(input logic [7:0] b1,
                                                 input logic [7:0] b2,
                                                 input logic [7:0] b3);
      return b1 ^ b2 ^ b3;
   endfunction

   // Error counter step that sticks at 8'hFF instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? 8'hFF : value + 8'd1;
   endfunction

endpackage

// File: rtl/uart_byte_timeout.sv
// ---------------------------------------------------------------------------
// uart_byte_timeout
// Inter-byte watchdog for the framer. Counts clock cycles while a frame is
// open and flags expiry when the count reaches TIMEOUT_CYCLES-1 with no byte
// arriving that cycle; an arriving byte always wins over expiry.
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous reset, active-high
//   enable  in  frame open (counter runs); low holds the counter at 0
//   clear   in  byte accepted this cycle (restarts the count)
//   expired out combinational expiry flag, sampled by the framer FSM
// ---------------------------------------------------------------------------
module uart_byte_timeout #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic clear,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count_r;

   // Expiry requires an open frame and no byte this cycle.
   always_comb begin
      expired = 1'b0;
      if (enable && !clear && (count_r == LAST)) begin
         expired = 1'b1;
      end else begin
         expired = 1'b0;
      end
   end

   // Gap counter: zero while idle or on a byte, otherwise counts up to LAST.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= '0;
      end else if (!enable || clear || (count_r == LAST)) begin
         count_r <= '0;
      end else begin
         count_r <= count_r + CW'(1);
      end
   end

endmodule

// File: rtl/uart_cmd_framer.sv
// ---------------------------------------------------------------------------
// uart_cmd_framer
// Assembles HEADER,B1,B2,B3,CK byte frames from the UART receiver into a
// 20-bit command word {B1[3:0],B2,B3}. A good frame is presented for one
// cycle; bad checksums, a nonzero B1 upper nibble and inter-byte timeouts
// give a one-cycle frame_err and bump a saturating error counter.
// Ports:
//   clk        in  system clock
//   rst        in  asynchronous reset, active-high
//   rx_data    in  [7:0]  received byte
//   rx_valid   in  one-cycle strobe qualifying rx_data
//   cmd_data   out [19:0] command word; IDLE_WORD except in the cmd_valid cycle
//   cmd_valid  out one-cycle strobe with a valid cmd_data
//   frame_err  out one-cycle strobe per rejected frame
//   err_cnt    out [7:0]  saturating count of rejected frames
// ---------------------------------------------------------------------------
module uart_cmd_framer
   import uart_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 50000,
   parameter logic [7:0]  HEADER         = HEADER_DEFAULT,
   parameter logic [19:0] IDLE_WORD      = IDLE_WORD_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [19:0] cmd_data,
   output logic        cmd_valid,
   output logic        frame_err,
   output logic [7:0]  err_cnt
);

   frame_state_t state_r;
   logic [7:0]   b1_r;
   logic [7:0]   b2_r;
   logic [7:0]   b3_r;
   logic         tmo_expired_s;

   uart_byte_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .enable (state_r != ST_IDLE),
      .clear  (rx_valid),
      .expired(tmo_expired_s)
   );

   // Frame FSM with registered outputs. Every terminal path returns to IDLE
   // on the same edge that registers its outcome, so a HEADER arriving in the
   // very next cycle is picked up normally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         b1_r      <= 8'h00;
         b2_r      <= 8'h00;
         b3_r      <= 8'h00;
         cmd_data  <= IDLE_WORD;
         cmd_valid <= 1'b0;
         frame_err <= 1'b0;
         err_cnt   <= 8'h00;
      end else begin
         cmd_data  <= IDLE_WORD;
         cmd_valid <= 1'b0;
         frame_err <= 1'b0;
         if (tmo_expired_s) begin
            state_r   <= ST_IDLE;
            frame_err <= 1'b1;
            err_cnt   <= sat_inc8(err_cnt);
         end else begin
            case (state_r)
               ST_IDLE: begin
                  // Non-header bytes between frames are line noise: dropped.
                  if (rx_valid && (rx_data == HEADER)) begin
                     state_r <= ST_GOT_HDR;
                  end
               end
               ST_GOT_HDR: begin
                  if (rx_valid) begin
                     b1_r    <= rx_data;
                     state_r <= ST_GOT_B1;
                  end
               end
               ST_GOT_B1: begin
                  if (rx_valid) begin
                     b2_r    <= rx_data;
                     state_r <= ST_GOT_B2;
                  end
               end
               ST_GOT_B2: begin
                  if (rx_valid) begin
                     b3_r    <= rx_data;
                     state_r <= ST_GOT_B3;
                  end
               end
               ST_GOT_B3: begin
                  if (rx_valid) begin
                     state_r <= ST_IDLE;
                     // The B1 nibble check rides on the checksum byte so a
                     // misaligned frame is caught by one decision point.
                     if ((rx_data == frame_checksum(b1_r, b2_r, b3_r)) &&
                         (b1_r[7:4] == 4'h0)) begin
                        cmd_valid <= 1'b1;
                        cmd_data  <= {b1_r[3:0], b2_r, b3_r};
                     end else begin
                        frame_err <= 1'b1;
                        err_cnt   <= sat_inc8(err_cnt);
                     end
                  end
               end
               default: begin
                  state_r <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_framer.sv
module tb_uart_cmd_framer;

   localparam int T = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [19:0] cmd_data;
   logic        cmd_valid;
   logic        frame_err;
   logic [7:0]  err_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_cmd_framer #(
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .cmd_data (cmd_data),
      .cmd_valid(cmd_valid),
      .frame_err(frame_err),
      .err_cnt  (err_cnt)
   );

   // ---------------- reference model (frame-level) ----------------
   logic [7:0]  m_q[$];      // bytes collected after the header
   bit          m_busy;      // a frame is open
   int          m_gap;       // idle edges since the last byte of the open frame
   logic [7:0]  m_cnt;
   logic        m_valid;
   logic [19:0] m_data;
   logic        m_err;

   logic [8:0]  stim[$];     // {valid, data} per clock

   function automatic void model_reset();
      m_q.delete();
      m_busy  = 0;
      m_gap   = 0;
      m_cnt   = 8'h00;
      m_valid = 1'b0;
      m_data  = 20'h00000;
      m_err   = 1'b0;
   endfunction

   function automatic void model_reject();
      m_err  = 1'b1;
      m_cnt  = (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1;
      m_busy = 0;
   endfunction

   function automatic void model_edge(input logic v, input logic [7:0] d);
      int word;
      m_valid = 1'b0;
      m_data  = 20'h00000;
      m_err   = 1'b0;
      if (!m_busy) begin
         if (v && d == 8'hA5) begin
            m_busy = 1;
            m_q.delete();
            m_gap = 0;
         end
      end else if (v) begin
         m_q.push_back(d);
         m_gap = 0;
         if (m_q.size() == 4) begin
            if (m_q[3] == (m_q[0] ^ m_q[1] ^ m_q[2]) && m_q[0] < 16) begin
               word    = m_q[0] * 65536 + m_q[1] * 256 + m_q[2];
               m_valid = 1'b1;
               m_data  = word[19:0];
               m_busy  = 0;
            end else begin
               model_reject();
            end
         end
      end else begin
         m_gap++;
         if (m_gap >= T) model_reject();
      end
   endfunction

   // ---------------- stimulus helpers ----------------
   function automatic void add_byte(input logic [7:0] d, input int gap);
      for (int i = 0; i < gap; i++) stim.push_back({1'b0, 8'($urandom)});
      stim.push_back({1'b1, d});
   endfunction

   function automatic void add_frame(input logic [7:0] b1, input logic [7:0] b2,
                                     input logic [7:0] b3, input logic [7:0] ck);
      add_byte(8'hA5, 0);
      add_byte(b1, 0);
      add_byte(b2, 0);
      add_byte(b3, 0);
      add_byte(ck, 0);
   endfunction

   task automatic step(input logic [8:0] it);
      @(negedge clk);
      rx_valid = it[8];
      rx_data  = it[7:0];
      @(posedge clk);
      model_edge(it[8], it[7:0]);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      model_reset();
      #12;
      total++;
      if ({cmd_valid, cmd_data, frame_err, err_cnt} !== {1'b0, 20'h00000, 1'b0, 8'h00}) begin
         bad++;
         $display("FAIL reset: got v=%0b d=%05h e=%0b cnt=%0d, want all zero",
                  cmd_valid, cmd_data, frame_err, err_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_good_frames();
      add_frame(8'h0F, 8'hFF, 8'hE4, 8'h14);
      while (stim.size() != 0) begin
         step(stim.pop_front());
         total++;
         if ({cmd_valid, cmd_data, frame_err, err_cnt} !== {m_valid, m_data, m_err, m_cnt}) begin
            bad++;
            $display("FAIL good_frames: got v=%0b d=%05h e=%0b cnt=%0d, want v=%0b d=%05h e=%0b cnt=%0d",
                     cmd_valid, cmd_data, frame_err, err_cnt, m_valid, m_data, m_err, m_cnt);
         end
      end
      total++;
      if (cmd_valid !== 1'b1 || cmd_data !== 20'hFFFE4) begin
         bad++;
         $display("FAIL good_fffe4: got v=%0b d=%05h, want v=1 d=fffe4", cmd_valid, cmd_data);
      end
      add_byte(8'h00, 1);
      add_frame(8'h0F, 8'hD1, 8'hF4, 8'h2A);
      for (int k = 0; k < 8; k++) begin
         logic [19:0] w;
         w = 20'($urandom);
         add_frame({4'h0, w[19:16]}, w[15:8], w[7:0], {4'h0, w[19:16]} ^ w[15:8] ^ w[7:0]);
      end
      while (stim.size() != 0) begin
         step(stim.pop_front());
         total++;
         if ({cmd_valid, cmd_data, frame_err, err_cnt} !== {m_valid, m_data, m_err, m_cnt}) begin
            bad++;
            $display("FAIL good_frames: got v=%0b d=%05h e=%0b cnt=%0d, want v=%0b d=%05h e=%0b cnt=%0d",
                     cmd_valid, cmd_data, frame_err, err_cnt, m_valid, m_data, m_err, m_cnt);
         end
      end
   endtask

   task automatic test_bad_frames();
      add_frame(8'h0F, 8'hD1, 8'hF4, 8'h00);
      while (stim.size() != 0) begin
         step(stim.pop_front());
         total++;
         if ({cmd_valid, cmd_data, frame_err, err_cnt} !== {m_valid, m_data, m_err, m_cnt}) begin
            bad++;
            $display("FAIL bad_frames: got v=%0b d=%05h e=%0b cnt=%0d, want v=%0b d=%05h e=%0b cnt=%0d",
                     cmd_valid, cmd_data, frame_err, err_cnt, m_valid, m_data, m_err, m_cnt);
         end
      end
      total++;
      if (frame_err !== 1'b1 || err_cnt !== 8'd1 || cmd_valid !== 1'b0) begin
         bad++;
         $display("FAIL bad_ck: got e=%0b cnt=%0d v=%0b, want e=1 cnt=1 v=0", frame_err, err_cnt, cmd_valid);
      end
      add_frame(8'h1F, 8'hFF, 8'hF0, 8'h10);
      while (stim.size() != 0) begin
         step(stim.pop_front());
         total++;
         if ({cmd_valid, cmd_data, frame_err, err_cnt} !== {m_valid, m_data, m_err, m_cnt}) begin
            bad++;
            $display("FAIL bad_frames: got v=%0b d=%05h e=%0b cnt=%0d, want v=%0b d=%05h e=%0b cnt=%0d",
                     cmd_valid, cmd_data, frame_err, err_cnt, m_valid, m_data, m_err, m_cnt);
         end
      end
      total++;
      if (frame_err !== 1'b1 || err_cnt !== 8'd2 || cmd_valid !== 1'b0) begin
         bad++;
         $display("FAIL bad_nibble: got e=%0b cnt=%0d v=%0b, want e=1 cnt=2 v=0", frame_err, err_cnt, cmd_valid);
      end
      add_byte(8'h00, 1);
      add_byte(8'h33, 0);
      add_frame(8'h0F, 8'hFF, 8'hE4, 8'h14);
      while (stim.size() != 0) begin
         step(stim.pop_front());
         total++;
         if ({cmd_valid, cmd_data, frame_err, err_cnt} !== {m_valid, m_data, m_err, m_cnt}) begin
            bad++;
            $display("FAIL garbage: got v=%0b d=%05h e=%0b cnt=%0d, want v=%0b d=%05h e=%0b cnt=%0d",
                     cmd_valid, cmd_data, frame_err, err_cnt, m_valid, m_data, m_err, m_cnt);
         end
      end
      total++;
      if (err_cnt !== 8'd2 || cmd_valid !== 1'b1) begin
         bad++;
         $display("FAIL garbage_cnt: got cnt=%0d v=%0b, want cnt=2 v=1", err_cnt, cmd_valid);
      end
   endtask

   task automatic test_timeout();
      logic [7:0] cnt_before;
      cnt_before = m_cnt;
      add_byte(8'hA5, 0);
      add_byte(8'h0F, 0);
      for (int i = 0; i < T; i++) stim.push_back({1'b0, 8'h00});
      while (stim.size() != 0) begin
         step(stim.pop_front());
         total++;
         if ({cmd_valid, cmd_data, frame_err, err_cnt} !== {m_valid, m_data, m_err, m_cnt}) begin
            bad++;
            $display("FAIL timeout: got v=%0b d=%05h e=%0b cnt=%0d, want v=%0b d=%05h e=%0b cnt=%0d",
                     cmd_valid, cmd_data, frame_err, err_cnt, m_valid, m_data, m_err, m_cnt);
         end
      end
      total++;
      if (frame_err !== 1'b1 || err_cnt !== cnt_before + 8'd1) begin
         bad++;
         $display("FAIL timeout_edge: got e=%0b cnt=%0d, want e=1 cnt=%0d", frame_err, err_cnt, cnt_before + 8'd1);
      end
      // byte lands on the last allowed cycle: must be taken
      add_byte(8'hA5, 0);
      add_byte(8'h0F, 0);
      add_byte(8'hD1, T - 1);
      add_byte(8'hF4, T - 1);
      add_byte(8'h2A, 0);
      while (stim.size() != 0) begin
         step(stim.pop_front());
         total++;
         if ({cmd_valid, cmd_data, frame_err, err_cnt} !== {m_valid, m_data, m_err, m_cnt}) begin
            bad++;
            $display("FAIL timeout_edge_ok: got v=%0b d=%05h e=%0b cnt=%0d, want v=%0b d=%05h e=%0b cnt=%0d",
                     cmd_valid, cmd_data, frame_err, err_cnt, m_valid, m_data, m_err, m_cnt);
         end
      end
      total++;
      if (cmd_valid !== 1'b1 || cmd_data !== 20'hFD1F4 || err_cnt !== cnt_before + 8'd1) begin
         bad++;
         $display("FAIL late_byte: got v=%0b d=%05h cnt=%0d, want v=1 d=fd1f4 cnt=%0d",
                  cmd_valid, cmd_data, err_cnt, cnt_before + 8'd1);
      end
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      add_frame(8'h0F, 8'hFF, 8'hE4, 8'h14);
      add_frame(8'h0F, 8'hD1, 8'hF4, 8'h2A);
      add_byte(8'h00, 2);
      while (stim.size() != 0) begin
         step(stim.pop_front());
         if (cmd_valid === 1'b1) pulses++;
         total++;
         if ({cmd_valid, cmd_data, frame_err, err_cnt} !== {m_valid, m_data, m_err, m_cnt}) begin
            bad++;
            $display("FAIL back_to_back: got v=%0b d=%05h e=%0b cnt=%0d, want v=%0b d=%05h e=%0b cnt=%0d",
                     cmd_valid, cmd_data, frame_err, err_cnt, m_valid, m_data, m_err, m_cnt);
         end
      end
      total++;
      if (pulses != 2) begin
         bad++;
         $display("FAIL b2b_pulses: got %0d pulses, want 2", pulses);
      end
   endtask

   task automatic test_random();
      for (int f = 0; f < 150; f++) begin
         logic [19:0] w;
         logic [7:0]  b1, ck;
         int          kind;
         w    = 20'($urandom);
         b1   = {4'h0, w[19:16]};
         kind = $urandom_range(0, 5);
         if (kind == 0) b1[7:4] = 4'($urandom_range(1, 15));
         ck = b1 ^ w[15:8] ^ w[7:0];
         if (kind == 1) ck = ck ^ 8'($urandom_range(1, 255));
         add_byte(8'hA5, $urandom_range(0, 3));
         add_byte(b1, (kind == 2) ? $urandom_range(T - 2, T + 1) : $urandom_range(0, 2));
         add_byte(w[15:8], $urandom_range(0, 1));
         add_byte(w[7:0], 0);
         add_byte(ck, $urandom_range(0, 1));
      end
      while (stim.size() != 0) begin
         step(stim.pop_front());
         total++;
         if ({cmd_valid, cmd_data, frame_err, err_cnt} !== {m_valid, m_data, m_err, m_cnt}) begin
            bad++;
            $display("FAIL random: got v=%0b d=%05h e=%0b cnt=%0d, want v=%0b d=%05h e=%0b cnt=%0d",
                     cmd_valid, cmd_data, frame_err, err_cnt, m_valid, m_data, m_err, m_cnt);
         end
      end
   endtask

   task automatic test_saturation();
      for (int f = 0; f < 260; f++) add_frame(8'h0F, 8'hFF, 8'hE4, 8'h00);
      while (stim.size() != 0) begin
         step(stim.pop_front());
         total++;
         if ({cmd_valid, cmd_data, frame_err, err_cnt} !== {m_valid, m_data, m_err, m_cnt}) begin
            bad++;
            $display("FAIL saturation: got v=%0b d=%05h e=%0b cnt=%0d, want v=%0b d=%05h e=%0b cnt=%0d",
                     cmd_valid, cmd_data, frame_err, err_cnt, m_valid, m_data, m_err, m_cnt);
         end
      end
      total++;
      if (err_cnt !== 8'hFF) begin
         bad++;
         $display("FAIL sat_value: got cnt=%0d, want 255", err_cnt);
      end
   endtask

   task automatic test_reset_mid_frame();
      add_byte(8'hA5, 0);
      add_byte(8'h0F, 0);
      add_byte(8'hD1, 0);
      while (stim.size() != 0) step(stim.pop_front());
      @(negedge clk);
      rx_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      total++;
      if ({cmd_valid, cmd_data, frame_err, err_cnt} !== {1'b0, 20'h00000, 1'b0, 8'h00}) begin
         bad++;
         $display("FAIL async_reset: got v=%0b d=%05h e=%0b cnt=%0d, want all zero",
                  cmd_valid, cmd_data, frame_err, err_cnt);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      add_byte(8'hF4, 0);
      add_byte(8'h2A, 0);
      add_byte(8'h00, 3);
      while (stim.size() != 0) begin
         step(stim.pop_front());
         total++;
         if ({cmd_valid, cmd_data, frame_err, err_cnt} !== {m_valid, m_data, m_err, m_cnt}) begin
            bad++;
            $display("FAIL post_reset: got v=%0b d=%05h e=%0b cnt=%0d, want v=%0b d=%05h e=%0b cnt=%0d",
                     cmd_valid, cmd_data, frame_err, err_cnt, m_valid, m_data, m_err, m_cnt);
         end
      end
      total++;
      if (err_cnt !== 8'h00 || frame_err !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_cnt: got cnt=%0d e=%0b, want cnt=0 e=0", err_cnt, frame_err);
      end
   endtask

   initial begin
      test_reset();
      test_good_frames();
      test_bad_frames();
      test_timeout();
      test_back_to_back();
      test_random();
      test_saturation();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
